// File: rtl/alu_cmd_driver.sv
// Command-side driver for a 32-bit combinational ALU: buffers commands in a FIFO,
// issues one per cycle and returns registered results with an echoed tag.
module alu_cmd_driver #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [2:0]       cmd_sel,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_sel,
    input  logic [31:0]      alu_r,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_r,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [CNT_W-1:0] op_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [31:0]      mem_a   [DEPTH];
    logic [31:0]      mem_b   [DEPTH];
    logic [2:0]       mem_sel [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          run;
    logic          full;
    logic          empty;
    logic          push;
    logic          load;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);

    // run holds cmd_ready low while in reset, keeping the path purely registered
    assign cmd_ready = run && !full;
    assign push      = cmd_valid && cmd_ready;
    assign load      = !empty && (!rsp_valid || rsp_ready);

    assign alu_a   = empty ? 32'd0 : mem_a[rd_idx];
    assign alu_b   = empty ? 32'd0 : mem_b[rd_idx];
    assign alu_sel = empty ? 3'd0  : mem_sel[rd_idx];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_idx]   <= cmd_a;
            mem_b[wr_idx]   <= cmd_b;
            mem_sel[wr_idx] <= cmd_sel;
            mem_tag[wr_idx] <= cmd_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run    <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            run <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (load) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_r     <= 32'd0;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_tag   <= '0;
        end else if (load) begin
            rsp_valid <= 1'b1;
            rsp_r     <= alu_r;
            rsp_zero  <= alu_zero;
            rsp_err   <= (mem_sel[rd_idx] >= 3'b101);
            rsp_tag   <= mem_tag[rd_idx];
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (rsp_valid && rsp_ready) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed and scoreboarded bench for alu_cmd_driver, built with a 4-bit op counter
// so counter wrap can be exercised; the bench also models the external ALU.
module tb_alu_cmd_driver;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [31:0]      cmd_a = '0;
    logic [31:0]      cmd_b = '0;
    logic [2:0]       cmd_sel = '0;
    logic [TAG_W-1:0] cmd_tag = '0;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [2:0]       alu_sel;
    logic [31:0]      alu_r;
    logic             alu_zero;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [31:0]      rsp_r;
    logic             rsp_zero;
    logic             rsp_err;
    logic [TAG_W-1:0] rsp_tag;
    logic [CNT_W-1:0] op_count;

    int checks = 0;
    int errors = 0;
    logic [37:0]      sb[$];
    logic [CNT_W-1:0] exp_count = '0;

    always #5 clk = ~clk;

    alu_cmd_driver #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_r(alu_r), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_r(rsp_r), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .rsp_tag(rsp_tag),
        .op_count(op_count)
    );

    // External ALU: illegal ops return 0
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] sel);
        case (sel)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return {31'd0, (a < b)};
            default: return 32'd0;
        endcase
    endfunction

    assign alu_r    = alu_fn(alu_a, alu_b, alu_sel);
    assign alu_zero = (alu_r == 32'd0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [37:0] expect_of(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] sel, input logic [3:0] tag);
        logic [31:0] r;
        r = alu_fn(a, b, sel);
        return {(sel >= 3'b101), (r == 32'd0), tag, r};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One clock with scoreboard accounting for whatever handshakes the current inputs make
    task automatic step(output bit acc);
        logic        hs_rsp;
        logic [37:0] e;
        hs_rsp = rsp_valid && rsp_ready;
        acc    = cmd_valid && cmd_ready;
        if (hs_rsp) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("rsp_r", rsp_r, e[31:0]);
                check("rsp_tag", 32'(rsp_tag), 32'(e[35:32]));
                check("rsp_zero", 32'(rsp_zero), 32'(e[36]));
                check("rsp_err", 32'(rsp_err), 32'(e[37]));
            end
        end
        if (acc) sb.push_back(expect_of(cmd_a, cmd_b, cmd_sel, cmd_tag));
        tick();
        if (hs_rsp) exp_count++;
        check("op_count", 32'(op_count), 32'(exp_count));
    endtask

    task automatic set_cmd(input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] sel, input logic [3:0] tag);
        cmd_valid = 1'b1;
        cmd_a = a;
        cmd_b = b;
        cmd_sel = sel;
        cmd_tag = tag;
    endtask

    task automatic rand_cmd;
        logic [31:0] a;
        a = $urandom;
        set_cmd(a, ($urandom_range(0, 3) == 0) ? a : $urandom, 3'($urandom_range(0, 7)),
                4'($urandom_range(0, 15)));
    endtask

    // Single command on an idle path with hand-computed expected result
    task automatic run_one(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] sel, input logic [3:0] tag,
                           input logic [31:0] er, input logic ez, input logic ee);
        bit acc;
        rsp_ready = 1'b1;
        set_cmd(a, b, sel, tag);
        check({nm, "_ready"}, 32'(cmd_ready), 32'd1);
        step(acc);
        cmd_valid = 1'b0;
        check({nm, "_lat1_valid"}, 32'(rsp_valid), 32'd0);
        check({nm, "_alu_a"}, alu_a, a);
        check({nm, "_alu_b"}, alu_b, b);
        check({nm, "_alu_sel"}, 32'(alu_sel), 32'(sel));
        step(acc);
        check({nm, "_valid"}, 32'(rsp_valid), 32'd1);
        check({nm, "_r"}, rsp_r, er);
        check({nm, "_zero"}, 32'(rsp_zero), 32'(ez));
        check({nm, "_err"}, 32'(rsp_err), 32'(ee));
        check({nm, "_tag"}, 32'(rsp_tag), 32'(tag));
        step(acc);
        check({nm, "_done"}, 32'(rsp_valid), 32'd0);
        check({nm, "_alu_idle"}, alu_a, 32'd0);
    endtask

    initial begin
        bit acc;
        int sent;
        int budget;
        logic [CNT_W-1:0] cnt_base;

        // Reset state
        #2;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_r", rsp_r, 32'd0);
        check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_alu_sel", 32'(alu_sel), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", 32'(cmd_ready), 32'd1);

        // 1 and 2: directed single operations
        run_one("t1_add", 32'd5, 32'd7, 3'b000, 4'd3, 32'd12, 1'b0, 1'b0);
        check("t1_count", 32'(op_count), 32'd1);
        run_one("t2_sub", 32'd9, 32'd9, 3'b001, 4'd1, 32'd0, 1'b1, 1'b0);
        run_one("t2_slt", 32'd1, 32'd2, 3'b100, 4'd2, 32'd1, 1'b0, 1'b0);
        run_one("t2_slt0", 32'd2, 32'd1, 3'b100, 4'd4, 32'd0, 1'b1, 1'b0);
        run_one("t2_and", 32'hF0F0_1234, 32'h0FF0_00FF, 3'b010, 4'd5, 32'h00F0_0034, 1'b0, 1'b0);
        run_one("t2_or", 32'hF000_0001, 32'h0000_0010, 3'b011, 4'd6, 32'hF000_0011, 1'b0, 1'b0);
        run_one("t2_ill", 32'd8, 32'd3, 3'b110, 4'd7, 32'd0, 1'b1, 1'b1);
        run_one("t2_addwrap", 32'hFFFF_FFFF, 32'd1, 3'b000, 4'd8, 32'd0, 1'b1, 1'b0);

        // 3: back-pressure fills 4 queued + 1 held, then drain at full rate
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_cmd(32'(100 + i), 32'(i), 3'b000, 4'(i));
            check("t3_ready", 32'(cmd_ready), 32'd1);
            step(acc);
        end
        check("t3_full", 32'(cmd_ready), 32'd0);
        check("t3_held", 32'(rsp_valid), 32'd1);
        check("t3_hold_tag", 32'(rsp_tag), 32'd0);
        step(acc);
        check("t3_stall_noacc", 32'(acc), 32'd0);
        check("t3_stable_r", rsp_r, 32'd100);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t3_drain_valid", 32'(rsp_valid), 32'd1);
            check("t3_drain_tag", 32'(rsp_tag), 32'(i));
            step(acc);
        end
        check("t3_empty", 32'(rsp_valid), 32'd0);
        check("t3_sb", 32'(sb.size()), 32'd0);

        // 4: full FIFO, toggling rsp_ready, held cmd_valid, 100 random commands
        rsp_ready = 1'b0;
        sent = 0;
        rand_cmd();
        budget = 0;
        while (cmd_ready && budget < 10) begin
            step(acc);
            if (acc) begin sent++; rand_cmd(); end
            budget++;
        end
        check("t4_filled", 32'(cmd_ready), 32'd0);
        budget = 0;
        while (sent < 100 && budget < 2000) begin
            rsp_ready = 1'($urandom_range(0, 1));
            step(acc);
            if (acc) begin sent++; rand_cmd(); end
            budget++;
        end
        check("t4_sent", 32'(sent), 32'd100);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        budget = 0;
        while ((sb.size() != 0 || rsp_valid) && budget < 20) begin
            step(acc);
            budget++;
        end
        check("t4_sb_empty", 32'(sb.size()), 32'd0);
        check("t4_idle", 32'(rsp_valid), 32'd0);

        // 5: reset mid-burst with 3 queued and 1 held
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_cmd(32'(i), 32'd1, 3'b000, 4'(i + 9));
            step(acc);
        end
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t5_cmd_ready", 32'(cmd_ready), 32'd0);
        check("t5_op_count", 32'(op_count), 32'd0);
        check("t5_alu_a", alu_a, 32'd0);
        sb.delete();
        exp_count = '0;
        tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(acc);
            check("t5_no_stale", 32'(rsp_valid), 32'd0);
        end
        check("t5_ready_back", 32'(cmd_ready), 32'd1);

        // 6: 16 responses wrap the 4-bit counter back to 0
        cnt_base = op_count;
        for (int i = 0; i < 16; i++) begin
            set_cmd(32'(i), 32'(2 * i), 3'b011, 4'(i));
            step(acc);
            if (!acc) check("t6_acc", 32'(acc), 32'd1);
        end
        cmd_valid = 1'b0;
        budget = 0;
        while ((sb.size() != 0 || rsp_valid) && budget < 20) begin
            if (sb.size() == 1 && rsp_valid) check("t6_pre_wrap", 32'(op_count), 32'd15);
            step(acc);
            budget++;
        end
        check("t6_base", 32'(cnt_base), 32'd0);
        check("t6_wrap", 32'(op_count), 32'd0);
        check("t6_sb", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
